// File: rtl/des_vector_driver_pkg.sv
// -----------------------------------------------------------------------------
// des_test_pkg
// Shared types and constants for the design-slot vector driver.
//   des_vec_t   : one test vector {sel, stim, exp, mask} (42 bits)
//   dvd_state_e : driver sequencer states
//   des_diff()  : masked mismatch between a sampled output and its expectation
// -----------------------------------------------------------------------------
package des_test_pkg;

    localparam int DES_IO_W  = 12;
    localparam int DES_SEL_W = 6;

    typedef struct packed {
        logic [DES_SEL_W-1:0] sel;
        logic [DES_IO_W-1:0]  stim;
        logic [DES_IO_W-1:0]  exp;
        logic [DES_IO_W-1:0]  mask;
    } des_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RST    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } dvd_state_e;

    // Bits that differ from the expectation, restricted to the bits we care about.
    function automatic logic [DES_IO_W-1:0] des_diff(
        input logic [DES_IO_W-1:0] sample,
        input logic [DES_IO_W-1:0] exp_val,
        input logic [DES_IO_W-1:0] mask
    );
        return (sample ^ exp_val) & mask;
    endfunction

endpackage

// File: rtl/des_vector_driver_if.sv
// -----------------------------------------------------------------------------
// des_vector_driver_if
// Valid/ready vector stream into the driver.
//   vec_valid : producer offers a vector
//   vec_ready : driver can accept a vector
//   vec_data  : {sel, stim, exp, mask}
// Modports: master = vector producer, slave = driver.
// -----------------------------------------------------------------------------
interface des_vector_driver_if;
    import des_test_pkg::*;

    logic     vec_valid;
    logic     vec_ready;
    des_vec_t vec_data;

    modport master (output vec_valid, output vec_data, input vec_ready);
    modport slave  (input vec_valid, input vec_data, output vec_ready);

endinterface

// File: rtl/des_vector_driver_stats.sv
// -----------------------------------------------------------------------------
// des_vec_stats
// Pass/fail bookkeeping for the vector driver.
//   clock, reset   : clock, async active-low reset
//   clr            : synchronous clear, wins over a simultaneous strobe
//   chk_stb        : one check completes this cycle, with mismatch bits diff
//   vec_count      : vectors checked (saturating)
//   err_count      : mismatching vectors (saturating)
//   first_err_idx  : vec_count value at the first mismatch
//   err_seen       : a mismatch happened since reset/clr
//   last_diff      : diff of the latest check
// -----------------------------------------------------------------------------
module des_vec_stats
    import des_test_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clr,
    input  logic                chk_stb,
    input  logic [DES_IO_W-1:0] diff,
    output logic [CNT_W-1:0]    vec_count,
    output logic [CNT_W-1:0]    err_count,
    output logic [CNT_W-1:0]    first_err_idx,
    output logic                err_seen,
    output logic [DES_IO_W-1:0] last_diff
);

    logic [CNT_W-1:0]    vec_count_d, vec_count_q;
    logic [CNT_W-1:0]    err_count_d, err_count_q;
    logic [CNT_W-1:0]    first_err_idx_d, first_err_idx_q;
    logic                err_seen_d, err_seen_q;
    logic [DES_IO_W-1:0] last_diff_d, last_diff_q;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        vec_count_d     = vec_count_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        err_seen_d      = err_seen_q;
        last_diff_d     = last_diff_q;
        if (clr) begin
            vec_count_d     = '0;
            err_count_d     = '0;
            first_err_idx_d = '0;
            err_seen_d      = 1'b0;
            last_diff_d     = '0;
        end else if (chk_stb) begin
            last_diff_d = diff;
            vec_count_d = sat_inc(vec_count_q);
            if (diff != '0) begin
                err_count_d = sat_inc(err_count_q);
                if (!err_seen_q) begin
                    // Index is the count before this vector is added.
                    first_err_idx_d = vec_count_q;
                    err_seen_d      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vec_count_q     <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            err_seen_q      <= 1'b0;
            last_diff_q     <= '0;
        end else begin
            vec_count_q     <= vec_count_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            err_seen_q      <= err_seen_d;
            last_diff_q     <= last_diff_d;
        end
    end

    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign err_seen      = err_seen_q;
    assign last_diff     = last_diff_q;

endmodule

// File: rtl/des_vector_driver.sv
// -----------------------------------------------------------------------------
// des_vector_driver
// Drives one test vector at a time into a selected design slot: optionally
// resets the slot (on a slot change or after reset/clr), applies the stimulus,
// waits a settle time, samples the slot output and checks it against a masked
// expectation.
//   clock, reset    : clock (also the design clock), async active-low reset
//   vec_if (slave)  : vector stream {sel, stim, exp, mask}, valid/ready
//   clr             : sync clear of statistics, aborts the in-flight vector
//   drv_sel         : slot select to the multiplexer
//   drv_io_in       : stimulus to the selected slot
//   drv_reset       : active-high reset to the selected slot
//   dut_io_out      : output returned by the selected slot
//   busy, chk_done  : vector in flight / one-cycle check-complete pulse
//   vec_count, err_count, first_err_idx, err_seen, last_diff : statistics
// Build option: define DES_VECTOR_SYNC_CAPTURE_EN to pass dut_io_out through
// a 2-flop synchroniser; the settle phase is then 2 cycles longer.
// -----------------------------------------------------------------------------
module des_vector_driver
    import des_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int RST_CYCLES    = 2,
    parameter int CNT_W         = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    des_vector_driver_if.slave   vec_if,
    input  logic                 clr,
    output logic [DES_SEL_W-1:0] drv_sel,
    output logic [DES_IO_W-1:0]  drv_io_in,
    output logic                 drv_reset,
    input  logic [DES_IO_W-1:0]  dut_io_out,
    output logic                 busy,
    output logic                 chk_done,
    output logic [CNT_W-1:0]     vec_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     first_err_idx,
    output logic                 err_seen,
    output logic [DES_IO_W-1:0]  last_diff
);

`ifdef DES_VECTOR_SYNC_CAPTURE_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif
    localparam int SETTLE_LOAD = SETTLE_CYCLES - 1 + SYNC_EXTRA;
    localparam int CTR_MAX     = (RST_CYCLES > SETTLE_LOAD + 1) ? RST_CYCLES : SETTLE_LOAD + 1;
    localparam int CTR_W       = $clog2(CTR_MAX + 1);

    dvd_state_e           state_d, state_q;
    logic [CTR_W-1:0]     ctr_d, ctr_q;
    logic [DES_SEL_W-1:0] sel_d, sel_q;
    logic [DES_IO_W-1:0]  io_d, io_q;
    logic [DES_IO_W-1:0]  stim_d, stim_q;
    logic [DES_IO_W-1:0]  exp_d, exp_q;
    logic [DES_IO_W-1:0]  mask_d, mask_q;
    logic                 drv_rst_d, drv_rst_q;
    logic                 need_rst_d, need_rst_q;
    logic                 chk_done_d, chk_done_q;
    logic                 chk_stb;
    logic [DES_IO_W-1:0]  sample;
    logic [DES_IO_W-1:0]  diff;
    des_vec_t             vec_in;

    assign vec_in = vec_if.vec_data;

`ifdef DES_VECTOR_SYNC_CAPTURE_EN
    logic [DES_IO_W-1:0] sync1_q, sync2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= dut_io_out;
            sync2_q <= sync1_q;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = dut_io_out;
`endif

    assign diff = des_diff(sample, exp_q, mask_q);

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        sel_d      = sel_q;
        io_d       = io_q;
        stim_d     = stim_q;
        exp_d      = exp_q;
        mask_d     = mask_q;
        drv_rst_d  = drv_rst_q;
        need_rst_d = need_rst_q;
        chk_stb    = 1'b0;
        if (clr) begin
            // Abort whatever is in flight; the next vector re-resets its slot.
            state_d    = ST_IDLE;
            need_rst_d = 1'b1;
            drv_rst_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (vec_if.vec_valid) begin
                        exp_d  = vec_in.exp;
                        mask_d = vec_in.mask;
                        if (need_rst_q || (vec_in.sel != sel_q)) begin
                            // Stimulus is held back until the slot leaves reset.
                            sel_d     = vec_in.sel;
                            stim_d    = vec_in.stim;
                            drv_rst_d = 1'b1;
                            ctr_d     = CTR_W'(RST_CYCLES - 1);
                            state_d   = ST_RST;
                        end else begin
                            io_d    = vec_in.stim;
                            ctr_d   = CTR_W'(SETTLE_LOAD);
                            state_d = ST_SETTLE;
                        end
                    end
                end
                ST_RST: begin
                    if (ctr_q == '0) begin
                        drv_rst_d  = 1'b0;
                        io_d       = stim_q;
                        need_rst_d = 1'b0;
                        ctr_d      = CTR_W'(SETTLE_LOAD);
                        state_d    = ST_SETTLE;
                    end else begin
                        ctr_d = ctr_q - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (ctr_q == '0) begin
                        state_d = ST_CHECK;
                    end else begin
                        ctr_d = ctr_q - 1'b1;
                    end
                end
                ST_CHECK: begin
                    chk_stb = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        chk_done_d = chk_stb;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ctr_q      <= '0;
            sel_q      <= '0;
            io_q       <= '0;
            stim_q     <= '0;
            exp_q      <= '0;
            mask_q     <= '0;
            drv_rst_q  <= 1'b1;
            need_rst_q <= 1'b1;
            chk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            sel_q      <= sel_d;
            io_q       <= io_d;
            stim_q     <= stim_d;
            exp_q      <= exp_d;
            mask_q     <= mask_d;
            drv_rst_q  <= drv_rst_d;
            need_rst_q <= need_rst_d;
            chk_done_q <= chk_done_d;
        end
    end

    assign vec_if.vec_ready = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign drv_sel          = sel_q;
    assign drv_io_in        = io_q;
    assign drv_reset        = drv_rst_q;
    assign chk_done         = chk_done_q;

    des_vec_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clock         (clock),
        .reset         (reset),
        .clr           (clr),
        .chk_stb       (chk_stb),
        .diff          (diff),
        .vec_count     (vec_count),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .err_seen      (err_seen),
        .last_diff     (last_diff)
    );

endmodule

// File: tb/tb_des_vector_driver.sv
// -----------------------------------------------------------------------------
// tb_des_vector_driver
// Directed bench for des_vector_driver with a two-slot design model
// (slot 1 loops back, slot 3 flips bit 0). Counters are built 4 bits wide so
// saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_des_vector_driver;
    import des_test_pkg::*;

    localparam int SETTLE_CYCLES = 4;
    localparam int RST_CYCLES    = 2;
    localparam int CNT_W         = 4;
`ifdef DES_VECTOR_SYNC_CAPTURE_EN
    localparam int S_EFF = SETTLE_CYCLES + 2;
`else
    localparam int S_EFF = SETTLE_CYCLES;
`endif
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             clr   = 1'b0;
    logic [5:0]       drv_sel;
    logic [11:0]      drv_io_in;
    logic             drv_reset;
    logic [11:0]      dut_io_out;
    logic             busy;
    logic             chk_done;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] first_err_idx;
    logic             err_seen;
    logic [11:0]      last_diff;

    des_vector_driver_if vif ();

    des_vector_driver #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .RST_CYCLES    (RST_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .vec_if        (vif),
        .clr           (clr),
        .drv_sel       (drv_sel),
        .drv_io_in     (drv_io_in),
        .drv_reset     (drv_reset),
        .dut_io_out    (dut_io_out),
        .busy          (busy),
        .chk_done      (chk_done),
        .vec_count     (vec_count),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .err_seen      (err_seen),
        .last_diff     (last_diff)
    );

    always #5 clock = ~clock;

    // Slot model seen by the driver.
    function automatic logic [11:0] slot_out(input logic [5:0] sel, input logic [11:0] stim);
        if (sel == 6'd1) return stim;
        if (sel == 6'd3) return stim ^ 12'h001;
        return 12'h000;
    endfunction

    assign dut_io_out = slot_out(drv_sel, drv_io_in);

    typedef struct {
        int vc;
        int ec;
        int fi;
        int seen;
        int ld;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    // Reference statistics and slot-reset state.
    int   m_vc, m_ec, m_fi, m_seen;
    bit   m_need_rst;
    logic [5:0] m_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_vc = 0; m_ec = 0; m_fi = 0; m_seen = 0;
        m_need_rst = 1'b1;
    endtask

    task automatic push_expect(input logic [11:0] diff);
        exp_t e;
        if (diff != 12'h000) begin
            if (m_ec < CMAX) m_ec++;
            if (m_seen == 0) begin
                m_fi   = m_vc;
                m_seen = 1;
            end
        end
        if (m_vc < CMAX) m_vc++;
        e.vc = m_vc; e.ec = m_ec; e.fi = m_fi; e.seen = m_seen; e.ld = int'(diff);
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (vif.vec_ready !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("vec_ready_wait", {31'd0, vif.vec_ready}, 32'd1);
    endtask

    // Offer one vector, then follow it through to chk_done and score it.
    task automatic send(input logic [5:0] sel, input logic [11:0] stim,
                        input logic [11:0] expv, input logic [11:0] mask);
        bit   rst_ph;
        int   lat;
        int   n;
        bit   seen_done;
        exp_t e;
        wait_ready();
        rst_ph = m_need_rst || (sel != m_sel);
        lat    = 1 + S_EFF + (rst_ph ? RST_CYCLES : 0);
        vif.vec_valid = 1'b1;
        vif.vec_data  = {sel, stim, expv, mask};
        @(posedge clock); #1;
        vif.vec_valid = 1'b0;
        vif.vec_data  = des_vec_t'({$urandom, $urandom});
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("drv_sel", {26'd0, drv_sel}, {26'd0, sel});
        check("drv_reset_phase", {31'd0, drv_reset}, {31'd0, rst_ph});
        if (!rst_ph) check("stim_applied", {20'd0, drv_io_in}, {20'd0, stim});
        m_sel      = sel;
        m_need_rst = 1'b0;
        push_expect((slot_out(sel, stim) ^ expv) & mask);
        seen_done = 1'b0;
        n = 0;
        while (!seen_done && n < lat + 10) begin
            @(posedge clock); #1;
            n++;
            if (rst_ph && n == RST_CYCLES) begin
                check("drv_reset_release", {31'd0, drv_reset}, 32'd0);
                check("stim_after_rst", {20'd0, drv_io_in}, {20'd0, stim});
            end
            if (chk_done === 1'b1) seen_done = 1'b1;
        end
        check("chk_done_latency", n, lat);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (seen_done) begin
                check("vec_count", {28'd0, vec_count}, e.vc);
                check("err_count", {28'd0, err_count}, e.ec);
                check("first_err_idx", {28'd0, first_err_idx}, e.fi);
                check("err_seen", {31'd0, err_seen}, e.seen);
                check("last_diff", {20'd0, last_diff}, e.ld);
                check("ready_with_done", {31'd0, vif.vec_ready}, 32'd1);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vec_ready"}, {31'd0, vif.vec_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_drv_sel"}, {26'd0, drv_sel}, 32'd0);
        check({tag, "_drv_io_in"}, {20'd0, drv_io_in}, 32'd0);
        check({tag, "_drv_reset"}, {31'd0, drv_reset}, 32'd1);
        check({tag, "_chk_done"}, {31'd0, chk_done}, 32'd0);
        check({tag, "_vec_count"}, {28'd0, vec_count}, 32'd0);
        check({tag, "_err_count"}, {28'd0, err_count}, 32'd0);
        check({tag, "_first_err_idx"}, {28'd0, first_err_idx}, 32'd0);
        check({tag, "_err_seen"}, {31'd0, err_seen}, 32'd0);
        check({tag, "_last_diff"}, {20'd0, last_diff}, 32'd0);
    endtask

    initial begin
        int saw;
        vif.vec_valid = 1'b0;
        vif.vec_data  = '0;
        model_clear();
        m_sel = 6'd0;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clock); #1;

        // Loopback slot, first vector performs the slot reset phase.
        send(6'd1, 12'hA5C, 12'hA5C, 12'hFFF);
        // Same slot, back to back: no reset phase.
        send(6'd1, 12'h123, 12'h123, 12'hFFF);
        // Slot change to the bit-0 flipping slot: mismatch on bit 0.
        send(6'd3, 12'h010, 12'h010, 12'hFFF);
        // Same slot, bit 0 masked off: no new error.
        send(6'd3, 12'h010, 12'h010, 12'hFFE);
        // Expectation matching the flipped output.
        send(6'd3, 12'h0F0, 12'h0F1, 12'hFFF);
        // Mask of zero never flags an error.
        send(6'd3, 12'hFFF, 12'h000, 12'h000);
        // Second mismatch: first_err_idx must keep its original value.
        send(6'd3, 12'h555, 12'h555, 12'h00F);

        // clr during SETTLE aborts the vector.
        wait_ready();
        vif.vec_valid = 1'b1;
        vif.vec_data  = {6'd3, 12'h111, 12'h111, 12'hFFF};
        @(posedge clock); #1;
        vif.vec_valid = 1'b0;
        @(posedge clock); #1;
        check("clr_in_settle_busy", {31'd0, busy}, 32'd1);
        clr = 1'b1;
        @(posedge clock); #1;
        clr = 1'b0;
        model_clear();
        check("clr_drv_reset", {31'd0, drv_reset}, 32'd1);
        check("clr_vec_count", {28'd0, vec_count}, 32'd0);
        check("clr_err_count", {28'd0, err_count}, 32'd0);
        check("clr_err_seen", {31'd0, err_seen}, 32'd0);
        check("clr_last_diff", {20'd0, last_diff}, 32'd0);
        check("clr_vec_ready", {31'd0, vif.vec_ready}, 32'd1);
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            if (chk_done === 1'b1) saw++;
            @(posedge clock); #1;
        end
        check("clr_no_chk_done", saw, 0);
        // Same slot after clr: reset phase again.
        send(6'd3, 12'h222, 12'h223, 12'hFFF);

        // Saturation: vec_count pins at max, then errors arrive.
        clr = 1'b1;
        @(posedge clock); #1;
        clr = 1'b0;
        model_clear();
        for (int i = 0; i < 17; i++) send(6'd1, 12'(i * 37), 12'(i * 37), 12'hFFF);
        check("vec_count_sat", {28'd0, vec_count}, CMAX);
        for (int i = 0; i < 20; i++) send(6'd1, 12'(i), 12'(i) ^ 12'h800, 12'hFFF);
        check("err_count_sat", {28'd0, err_count}, CMAX);
        check("first_err_idx_sat", {28'd0, first_err_idx}, CMAX);

        // Async reset in the middle of the slot reset phase.
        wait_ready();
        vif.vec_valid = 1'b1;
        vif.vec_data  = {6'd3, 12'h0AA, 12'h0AB, 12'hFFF};
        @(posedge clock); #1;
        vif.vec_valid = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clock); #1;
        reset = 1'b1;
        model_clear();
        m_sel = 6'd0;
        @(posedge clock); #1;
        check("post_reset_ready", {31'd0, vif.vec_ready}, 32'd1);
        check("post_reset_no_done", {31'd0, chk_done}, 32'd0);
        send(6'd1, 12'h3C3, 12'h3C3, 12'hFFF);

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
